// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage
//   Registered main decoder for the pipelined RV32I core. The Decode-stage
//   instruction is decoded combinationally and latched into the ID/EX control
//   register on the rising clock edge. Handles stall, flush (bubble), illegal
//   instruction detection and a saturating illegal-instruction counter.
//
//   Parameters
//     EN_EXT  0: base subset (lw/sw/add,sub,and,or,slt/addi,andi,ori,slti/beq/jal)
//             1: full RV32I integer set
//     CNT_W   width of the saturating illegal-instruction counter
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     InstrD, ValidD      instruction in Decode and its valid flag
//     StallE, FlushE      hold / bubble the ID/EX register (flush wins)
//     ValidE .. ImmSrcE   registered control for the Execute stage
//     IllegalE            Execute slot holds an illegal instruction
//     IllegalCnt          saturating count of illegal instructions accepted
// ---------------------------------------------------------------------------
module decode_ctrl_stage #(
    parameter bit EN_EXT = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      InstrD,
    input  logic             ValidD,
    input  logic             StallE,
    input  logic             FlushE,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic [2:0]       MemWidthE,
    output logic             JumpE,
    output logic             JalrE,
    output logic             BranchE,
    output logic [2:0]       BranchTypeE,
    output logic [3:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic [2:0]       ImmSrcE,
    output logic             IllegalE,
    output logic [CNT_W-1:0] IllegalCnt
);

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_BR    = 7'b1100011,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Bubble is the all-zero value of this struct.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] mem_width;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [2:0] branch_type;
        alu_op_e    alu_control;
        logic       alu_src;
        imm_src_e   imm_src;
        logic       illegal;
    } ctrl_t;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7b;

    assign op  = InstrD[6:0];
    assign f3  = InstrD[14:12];
    assign f7  = InstrD[31:25];
    assign f7b = InstrD[30];

    // Register fields are decoded elsewhere in the pipeline.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

    ctrl_t   dec;
    logic    legal;
    alu_op_e alu_f3;
    ctrl_t   ctrl_d;
    ctrl_t   ctrl_q;
    logic [CNT_W-1:0] cnt_q;

    // ALU operation shared by R-type and I-type arithmetic.
    always_comb begin
        alu_f3 = ALU_ADD;
        unique case (f3)
            3'b000:  alu_f3 = ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = f7b ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.imm_src    = IMM_I;
                dec.alu_control = ALU_ADD;
                dec.mem_width  = f3;
                legal = EN_EXT ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (f3 == 3'b010);
            end
            OP_STORE: begin
                dec.mem_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_S;
                dec.alu_control = ALU_ADD;
                dec.mem_width  = f3;
                legal = EN_EXT ? (f3 inside {3'b000, 3'b001, 3'b010})
                               : (f3 == 3'b010);
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_control = (f3 == 3'b000) ? (f7b ? ALU_SUB : ALU_ADD) : alu_f3;
                // 0100000 only selects sub / sra; any other funct7 is undefined.
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && (f3 inside {3'b000, 3'b101}));
                if (!EN_EXT && !(f3 inside {3'b000, 3'b010, 3'b110, 3'b111}))
                    legal = 1'b0;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_I;
                // For addi bit 30 is immediate data, never a sub select.
                dec.alu_control = (f3 == 3'b000) ? ALU_ADD : alu_f3;
                unique case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                if (!EN_EXT && !(f3 inside {3'b000, 3'b010, 3'b110, 3'b111}))
                    legal = 1'b0;
            end
            OP_BR: begin
                dec.branch      = 1'b1;
                dec.imm_src     = IMM_B;
                dec.branch_type = f3;
                case (f3[2:1])
                    2'b00:   dec.alu_control = ALU_SUB;
                    2'b10:   dec.alu_control = ALU_SLT;
                    default: dec.alu_control = ALU_SLTU;
                endcase
                legal = EN_EXT ? (f3[2:1] != 2'b01) : (f3 == 3'b000);
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.imm_src    = IMM_J;
                dec.result_src = 2'b10;
                legal = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_I;
                dec.result_src = 2'b10;
                dec.alu_control = ALU_ADD;
                legal = EN_EXT && (f3 == 3'b000);
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_U;
                dec.alu_control = ALU_PASSB;
                legal = EN_EXT;
            end
            OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMM_U;
                dec.result_src = 2'b11;
                legal = EN_EXT;
            end
            default: legal = 1'b0;
        endcase
    end

    // Final next-state value: bubble, illegal marker, or decoded control.
    always_comb begin
        ctrl_d = '0;
        if (ValidD) begin
            if (legal) begin
                ctrl_d       = dec;
                ctrl_d.valid = 1'b1;
            end else begin
                ctrl_d.valid   = 1'b1;
                ctrl_d.illegal = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else if (FlushE) begin
            ctrl_q <= '0;
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
            if (ctrl_d.illegal && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ValidE      = ctrl_q.valid;
    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign MemWidthE   = ctrl_q.mem_width;
    assign JumpE       = ctrl_q.jump;
    assign JalrE       = ctrl_q.jalr;
    assign BranchE     = ctrl_q.branch;
    assign BranchTypeE = ctrl_q.branch_type;
    assign ALUControlE = ctrl_q.alu_control;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ImmSrcE     = ctrl_q.imm_src;
    assign IllegalE    = ctrl_q.illegal;
    assign IllegalCnt  = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl_stage
//   Directed bench for decode_ctrl_stage. Two instances share all inputs:
//   dut_a with the full RV32I set (EN_EXT=1) and dut_b with the base subset
//   (EN_EXT=0). Expected control words are written out by hand per step.
// ---------------------------------------------------------------------------
module tb_decode_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstrD;
    logic        ValidD;
    logic        StallE;
    logic        FlushE;

    logic       v_a, rw_a, mw_a, j_a, jr_a, br_a, as_a, il_a;
    logic [1:0] rs_a;
    logic [2:0] mwid_a, bt_a, imm_a;
    logic [3:0] alu_a;
    logic [7:0] cnt_a;

    logic       v_b, rw_b, mw_b, j_b, jr_b, br_b, as_b, il_b;
    logic [1:0] rs_b;
    logic [2:0] mwid_b, bt_b, imm_b;
    logic [3:0] alu_b;
    logic [7:0] cnt_b;

    int total = 0;
    int bad   = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    logic [22:0] obs_a, obs_b, ill;

    assign obs_a = {v_a, rw_a, rs_a, mw_a, mwid_a, j_a, jr_a, br_a, bt_a, alu_a, as_a, imm_a, il_a};
    assign obs_b = {v_b, rw_b, rs_b, mw_b, mwid_b, j_b, jr_b, br_b, bt_b, alu_b, as_b, imm_b, il_b};

    decode_ctrl_stage #(.EN_EXT(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD),
        .StallE(StallE), .FlushE(FlushE),
        .ValidE(v_a), .RegWriteE(rw_a), .ResultSrcE(rs_a), .MemWriteE(mw_a),
        .MemWidthE(mwid_a), .JumpE(j_a), .JalrE(jr_a), .BranchE(br_a),
        .BranchTypeE(bt_a), .ALUControlE(alu_a), .ALUSrcE(as_a), .ImmSrcE(imm_a),
        .IllegalE(il_a), .IllegalCnt(cnt_a)
    );

    decode_ctrl_stage #(.EN_EXT(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD),
        .StallE(StallE), .FlushE(FlushE),
        .ValidE(v_b), .RegWriteE(rw_b), .ResultSrcE(rs_b), .MemWriteE(mw_b),
        .MemWidthE(mwid_b), .JumpE(j_b), .JalrE(jr_b), .BranchE(br_b),
        .BranchTypeE(bt_b), .ALUControlE(alu_b), .ALUSrcE(as_b), .ImmSrcE(imm_b),
        .IllegalE(il_b), .IllegalCnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word in output-port order.
    function automatic logic [22:0] cv(
        input logic v, input logic rw, input logic [1:0] rs, input logic mw,
        input logic [2:0] mwid, input logic j, input logic jr, input logic br,
        input logic [2:0] bt, input logic [3:0] alu, input logic as,
        input logic [2:0] imm, input logic il);
        return {v, rw, rs, mw, mwid, j, jr, br, bt, alu, as, imm, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] instr, input logic valid,
                        input logic stall, input logic flush);
        InstrD = instr;
        ValidD = valid;
        StallE = stall;
        FlushE = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'(exp_cnt_a));
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'(exp_cnt_b));
    endtask

    initial begin
        ill    = cv(1, 0, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 0, 3'b000, 1);
        rst_n  = 1'b0;
        InstrD = '0;
        ValidD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        #12;
        check("reset_a", 32'(obs_a), 32'd0);
        check_cnt("reset");
        rst_n = 1'b1;

        // Illegal entry before the mid-run reset, so the counter clear is visible.
        step(32'hFFFF_FFFF, 1, 0, 0);
        exp_cnt_a++; exp_cnt_b++;
        check("pre_ill_a", 32'(obs_a), 32'(ill));
        check_cnt("pre_ill");

        // Test 1: add loaded, then reset asserted between edges.
        step(32'h0000_0033, 1, 0, 0);
        check("add_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 0, 3'b000, 0)));
        #3;
        rst_n = 1'b0;
        #1;
        exp_cnt_a = 0; exp_cnt_b = 0;
        check("midrst_a", 32'(obs_a), 32'd0);
        check("midrst_b", 32'(obs_b), 32'd0);
        check_cnt("midrst");
        #2;
        rst_n = 1'b1;

        // Test 2: sub.
        step(32'h4031_00B3, 1, 0, 0);
        check("sub_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0001, 0, 3'b000, 0)));
        check("sub_b", 32'(obs_b), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0001, 0, 3'b000, 0)));

        // Test 3: add, two stalled cycles with jal presented, then stall+flush.
        step(32'h0000_0033, 1, 0, 0);
        step(32'h0000_006F, 1, 1, 0);
        check("stall1_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 0, 3'b000, 0)));
        step(32'h0000_006F, 1, 1, 0);
        check("stall2_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 0, 3'b000, 0)));
        step(32'h0000_006F, 1, 1, 1);
        check("flush_a", 32'(obs_a), 32'd0);
        check("flush_b", 32'(obs_b), 32'd0);

        step(32'h0000_006F, 1, 0, 0);
        check("jal_a", 32'(obs_a), 32'(cv(1, 1, 2'b10, 0, 3'b000, 1, 0, 0, 3'b000, 4'b0000, 0, 3'b011, 0)));
        check("jal_b", 32'(obs_b), 32'(cv(1, 1, 2'b10, 0, 3'b000, 1, 0, 0, 3'b000, 4'b0000, 0, 3'b011, 0)));

        // Test 4: jalr legal with EN_EXT=1, illegal with EN_EXT=0.
        step(32'h0000_80E7, 1, 0, 0);
        exp_cnt_b++;
        check("jalr_a", 32'(obs_a), 32'(cv(1, 1, 2'b10, 0, 3'b000, 0, 1, 0, 3'b000, 4'b0000, 1, 3'b000, 0)));
        check("jalr_b", 32'(obs_b), 32'(ill));
        check_cnt("jalr");

        // Test 6: blt, then the reserved f3=010 branch.
        step(32'h0020_C463, 1, 0, 0);
        exp_cnt_b++;
        check("blt_a", 32'(obs_a), 32'(cv(1, 0, 2'b00, 0, 3'b000, 0, 0, 1, 3'b100, 4'b0101, 0, 3'b010, 0)));
        check("blt_b", 32'(obs_b), 32'(ill));
        step(32'h0020_A463, 1, 0, 0);
        exp_cnt_a++; exp_cnt_b++;
        check("br010_a", 32'(obs_a), 32'(ill));
        check_cnt("br010");

        // Extended opcodes.
        step(32'h0000_10B7, 1, 0, 0);
        exp_cnt_b++;
        check("lui_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b1010, 1, 3'b100, 0)));
        check("lui_b", 32'(obs_b), 32'(ill));
        step(32'h0000_1097, 1, 0, 0);
        exp_cnt_b++;
        check("auipc_a", 32'(obs_a), 32'(cv(1, 1, 2'b11, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 0, 3'b100, 0)));
        step(32'h0000_8083, 1, 0, 0);
        exp_cnt_b++;
        check("lb_a", 32'(obs_a), 32'(cv(1, 1, 2'b01, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b000, 0)));
        check("lb_b", 32'(obs_b), 32'(ill));
        step(32'h0020_A023, 1, 0, 0);
        check("sw_a", 32'(obs_a), 32'(cv(1, 0, 2'b00, 1, 3'b010, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b001, 0)));
        check("sw_b", 32'(obs_b), 32'(cv(1, 0, 2'b00, 1, 3'b010, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b001, 0)));
        step(32'h4010_D093, 1, 0, 0);
        exp_cnt_b++;
        check("srai_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b1001, 1, 3'b000, 0)));
        check("srai_b", 32'(obs_b), 32'(ill));
        // R-type or with funct7=0100000 is undefined.
        step(32'h4010_6033, 1, 0, 0);
        exp_cnt_a++; exp_cnt_b++;
        check("rbad_a", 32'(obs_a), 32'(ill));
        check("rbad_b", 32'(obs_b), 32'(ill));
        check_cnt("rbad");
        step(32'h0000_0013, 1, 0, 0);
        check("nop_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b000, 0)));
        check("nop_b", 32'(obs_b), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b000, 0)));

        // Illegal under stall or flush must not count.
        step(32'hFFFF_FFFF, 1, 1, 0);
        check("stall_ill_a", 32'(obs_a), 32'(cv(1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 3'b000, 4'b0000, 1, 3'b000, 0)));
        check_cnt("stall_ill");
        step(32'hFFFF_FFFF, 1, 0, 1);
        check("flush_ill_a", 32'(obs_a), 32'd0);
        check_cnt("flush_ill");

        // Test 5: 300 illegal cycles saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            step(32'hFFFF_FFFF, 1, 0, 0);
        end
        exp_cnt_a = 255; exp_cnt_b = 255;
        check("sat_a", 32'(obs_a), 32'(ill));
        check_cnt("sat");
        step(32'hFFFF_FFFF, 0, 0, 0);
        check("novalid_a", 32'(obs_a), 32'd0);
        check("novalid_b", 32'(obs_b), 32'd0);
        check_cnt("novalid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
